bin_morph_3x3: RTL and testbench

Binary 3x3 morphology stage that sits directly downstream of the 1-bit line-shift buffer in the matrix_generate path. It takes the current-row pixel plus the two delayed-row taps, builds a 3x3 window, and applies erosion, dilation or bypass selected once per frame. Top and left border masking uses pixel and row counters. Frame sync signals are delayed to match the data latency so the stream can feed later binary stages unchanged.

---
 rtl/morph_pkg.sv | 27 ++
 rtl/window3x3_1bit.sv | 34 +++
 rtl/bin_morph_3x3.sv | 138 +++++++++++++
 tb/tb_bin_morph_3x3.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Shared mode encodings, pipeline latency and operator decode for the binary morphology stage.
package morph_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ERODE  = 2'b01;
  localparam logic [1:0] MODE_DILATE = 2'b10;

  localparam int unsigned MORPH_LAT = 2;

  typedef enum logic [1:0] {
    OpBypass,
    OpErode,
    OpDilate
  } op_e;

  // Unused encoding 2'b11 falls back to bypass.
  function automatic op_e decode_mode(input logic [1:0] m);
    op_e op;
    case (m)
      MODE_ERODE:  op = OpErode;
      MODE_DILATE: op = OpDilate;
      default:     op = OpBypass;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/window3x3_1bit.sv
// Strobe-gated 3x3 shift window of single-bit pixels.
// window[r*3+c]: r=0 is the current line, c=2 the newest column.
module window3x3_1bit
  import morph_pkg::*;
(
  input  logic       clock,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       row0_bit,
  input  logic       row1_bit,
  input  logic       row2_bit,
  output logic [8:0] window
);

  logic [2:0] row0_q;
  logic [2:0] row1_q;
  logic [2:0] row2_q;

  // Shift each row one column towards c=0 and load new taps into c=2; hold without strobe.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row0_q <= '0;
      row1_q <= '0;
      row2_q <= '0;
    end else if (clken) begin
      row0_q <= {row0_bit, row0_q[2:1]};
      row1_q <= {row1_bit, row1_q[2:1]};
      row2_q <= {row2_bit, row2_q[2:1]};
    end
  end

  assign window = {row2_q, row1_q, row0_q};

endmodule

// File: rtl/bin_morph_3x3.sv
// Binary 3x3 erode/dilate/bypass stage with top/left border masking and a fixed
// two-clock latency on data and frame sync signals.
module bin_morph_3x3
  import morph_pkg::*;
#(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter logic        BORDER_VAL = 1'b0
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic       row0_bit,
  input  logic       row1_bit,
  input  logic       row2_bit,
  input  logic [1:0] mode,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_bit
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_EDGE = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(2);

  logic [8:0]       win;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [1:0]       mode_q;
  logic             border_q;
  logic             vsync_d1, href_d1, clken_d1;
  logic             vsync_rise, href_fall;
  op_e              op;
  logic             result;

  window3x3_1bit u_window (
    .clock    (clock),
    .rst_n    (rst_n),
    .clken    (per_frame_clken),
    .row0_bit (row0_bit),
    .row1_bit (row1_bit),
    .row2_bit (row2_bit),
    .window   (win)
  );

  // Stage-1 sync copies double as the edge-detect history.
  assign vsync_rise = per_frame_vsync & ~vsync_d1;
  assign href_fall  = ~per_frame_href & href_d1;

  // Two-stage delay line for frame sync and strobe, running every clock.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1         <= 1'b0;
      href_d1          <= 1'b0;
      clken_d1         <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
    end else begin
      vsync_d1         <= per_frame_vsync;
      href_d1          <= per_frame_href;
      clken_d1         <= per_frame_clken;
      post_frame_vsync <= vsync_d1;
      post_frame_href  <= href_d1;
      post_frame_clken <= clken_d1;
    end
  end

  // Column counter: cleared outside href, counts strobes, saturates at the line end.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
    end else if (!per_frame_href) begin
      col_cnt <= '0;
    end else if (per_frame_clken && (col_cnt != COL_MAX)) begin
      col_cnt <= col_cnt + 1'b1;
    end
  end

  // Row counter: vsync rise clears (and wins over a coincident href fall), saturates at the bottom.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
    end else if (vsync_rise) begin
      row_cnt <= '0;
    end else if (href_fall && (row_cnt != ROW_MAX)) begin
      row_cnt <= row_cnt + 1'b1;
    end
  end

  // Mode is frozen for the whole frame at the vsync rising edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_BYPASS;
    end else if (vsync_rise) begin
      mode_q <= mode;
    end
  end

  // Border flag travels with the pixel into the window stage.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      border_q <= 1'b0;
    end else if (per_frame_clken) begin
      border_q <= (col_cnt < COL_EDGE) || (row_cnt < ROW_EDGE);
    end
  end

  // Operator on the registered window, with top/left masking for erode and dilate only.
  always_comb begin
    op     = decode_mode(mode_q);
    result = win[4];
    unique case (op)
      OpErode:  result = &win;
      OpDilate: result = |win;
      default:  result = win[4];
    endcase
    if ((op != OpBypass) && border_q) begin
      result = BORDER_VAL;
    end
  end

  // Output pixel register, updated only for strobed samples.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      post_img_bit <= 1'b0;
    end else if (clken_d1) begin
      post_img_bit <= result;
    end
  end

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Randomized and directed bench for bin_morph_3x3 against a frame-level model.
module tb_bin_morph_3x3;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int MAXR = 12;
  localparam int MAXC = 12;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic       b0 = 1'b0, b1 = 1'b0, b2 = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       p_vs, p_hr, p_ck, p_bit;

  always #5 clock = ~clock;

  bin_morph_3x3 #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(1'b0)) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .row0_bit         (b0),
    .row1_bit         (b1),
    .row2_bit         (b2),
    .mode             (mode),
    .post_frame_vsync (p_vs),
    .post_frame_href  (p_hr),
    .post_frame_clken (p_ck),
    .post_img_bit     (p_bit)
  );

  int   tests = 0;
  int   fails = 0;
  logic img      [MAXR][MAXC];
  logic tap      [3][MAXR][MAXC];
  logic dut_grid [MAXR][MAXC];

  // Model state: mode in force, last strobed row1 tap (window centre source), vsync history.
  logic [1:0] mode_lat = 2'b00;
  logic       prev_r1  = 1'b0;
  logic       vs_prev  = 1'b0;
  logic       exp_pix  = 1'b0;
  int         tag_r = 0, tag_c = 0;

  logic h1_vs = 0, h1_hr = 0, h1_ck = 0, h1_pix = 0;
  logic h2_vs = 0, h2_hr = 0, h2_ck = 0, h2_pix = 0;
  int   h1_r = 0, h1_c = 0, h2_r = 0, h2_c = 0;
  logic exp_hold = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Expected output for a strobed sample at stream position (r,c).
  function automatic logic model_pix(input int r, input int c);
    logic acc;
    if (mode_lat == 2'b01 || mode_lat == 2'b10) begin
      if (r < 2 || c < 2) return 1'b0;
      acc = (mode_lat == 2'b01);
      for (int k = 0; k < 3; k++)
        for (int j = c - 2; j <= c; j++)
          acc = (mode_lat == 2'b01) ? (acc & tap[k][r][j]) : (acc | tap[k][r][j]);
      return acc;
    end
    return prev_r1;
  endfunction

  // Expected stream: two-clock delay of what was driven, cleared by reset.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      h1_vs <= 0; h1_hr <= 0; h1_ck <= 0; h1_pix <= 0; h1_r <= 0; h1_c <= 0;
      h2_vs <= 0; h2_hr <= 0; h2_ck <= 0; h2_pix <= 0; h2_r <= 0; h2_c <= 0;
    end else begin
      h1_vs <= vsync; h1_hr <= href; h1_ck <= clken; h1_pix <= exp_pix;
      h1_r <= tag_r; h1_c <= tag_c;
      h2_vs <= h1_vs; h2_hr <= h1_hr; h2_ck <= h1_ck; h2_pix <= h1_pix;
      h2_r <= h1_r; h2_c <= h1_c;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (!rst_n) exp_hold = 1'b0;
    else if (h2_ck) begin
      exp_hold = h2_pix;
      dut_grid[h2_r][h2_c] = p_bit;
    end
    check("post_frame_vsync", p_vs, h2_vs);
    check("post_frame_href", p_hr, h2_hr);
    check("post_frame_clken", p_ck, h2_ck);
    check("post_img_bit", p_bit, exp_hold);
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic drive_cycle(input logic v, input logic h, input logic ck,
                             input logic x0, input logic x1, input logic x2,
                             input int r, input int c);
    if (v && !vs_prev) mode_lat = mode;
    vs_prev = v;
    vsync = v; href = h; clken = ck; b0 = x0; b1 = x1; b2 = x2;
    tag_r = r; tag_c = c;
    if (ck) begin
      exp_pix = model_pix(r, c);
      prev_r1 = x1;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, rb(), rb(), rb(), 0, 0);
  endtask

  task automatic reset_model();
    mode_lat = 2'b00; prev_r1 = 1'b0; vs_prev = 1'b0;
  endtask

  // Line-buffer taps: row1/row2 come from the previous lines of img; above the frame is garbage.
  task automatic pixel(input int r, input int c);
    logic x0, x1, x2;
    x0 = img[r][c];
    x1 = (r >= 1) ? img[r-1][c] : rb();
    x2 = (r >= 2) ? img[r-2][c] : rb();
    tap[0][r][c] = x0; tap[1][r][c] = x1; tap[2][r][c] = x2;
    drive_cycle(0, 1, 1, x0, x1, x2, r, c);
  endtask

  task automatic feed_line(input int r, input int len, input bit gapped);
    for (int c = 0; c < len; c++) begin
      if (gapped && c > 0) drive_cycle(0, 1, 0, rb(), rb(), rb(), 0, 0);
      pixel(r, c);
    end
    idle(2);
  endtask

  // kind: 0 random, 1 ones with a 0 at (3,4), 2 zeros with a 1 at (3,3), 3 checkerboard.
  task automatic run_frame(input logic [1:0] m, input int kind, input bit gapped,
                           input bit lead_line, input bit toggle, input int nlines,
                           input bit rand_len);
    for (int r = 0; r < MAXR; r++)
      for (int c = 0; c < MAXC; c++) begin
        dut_grid[r][c] = 1'bx;
        case (kind)
          1:       img[r][c] = !(r == 3 && c == 4);
          2:       img[r][c] = (r == 3 && c == 3);
          3:       img[r][c] = 1'((r + c) % 2);
          default: img[r][c] = rb();
        endcase
      end
    mode = m;
    // A lead line makes the href fall land on the same edge as the vsync rise.
    if (lead_line) for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, rb(), rb(), rb(), 0, 0);
    else idle(2);
    drive_cycle(1, 0, 0, rb(), rb(), rb(), 0, 0);
    drive_cycle(1, 0, 0, rb(), rb(), rb(), 0, 0);
    idle(2);
    for (int r = 0; r < nlines; r++) begin
      if (toggle && r == 2) mode = 2'b01;
      feed_line(r, rand_len ? int'($urandom_range(W + 3, 3)) : W, gapped);
    end
    idle(3);
  endtask

  task automatic erode_checks(input string tag);
    check({tag, "_e22"}, dut_grid[2][2], 1'b1);
    check({tag, "_e15"}, dut_grid[1][5], 1'b0);
    check({tag, "_e51"}, dut_grid[5][1], 1'b0);
    check({tag, "_e34"}, dut_grid[3][4], 1'b0);
    check({tag, "_e56"}, dut_grid[5][6], 1'b0);
    check({tag, "_e33"}, dut_grid[3][3], 1'b1);
    check({tag, "_e57"}, dut_grid[5][7], 1'b1);
    check({tag, "_e27"}, dut_grid[2][7], 1'b1);
  endtask

  task automatic dilate_checks(input string tag);
    check({tag, "_d33"}, dut_grid[3][3], 1'b1);
    check({tag, "_d44"}, dut_grid[4][4], 1'b1);
    check({tag, "_d55"}, dut_grid[5][5], 1'b1);
    check({tag, "_d23"}, dut_grid[2][3], 1'b0);
    check({tag, "_d32"}, dut_grid[3][2], 1'b0);
    check({tag, "_d56"}, dut_grid[5][6], 1'b0);
  endtask

  initial begin
    // Reset with arbitrary inputs.
    for (int i = 0; i < 5; i++) begin
      vsync = rb(); href = rb(); clken = rb(); b0 = rb(); b1 = rb(); b2 = rb();
      mode = 2'($urandom);
      @(posedge clock); #1;
      check("reset_vsync", p_vs, 1'b0);
      check("reset_bit", p_bit, 1'b0);
    end
    vsync = 0; href = 0; clken = 0; mode = 2'b00;
    reset_model();
    rst_n = 1'b1;
    idle(2);
    check("post_release_clken", p_ck, 1'b0);
    check("post_release_bit", p_bit, 1'b0);
    idle(2);

    // Latency pulses.
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("lat_vs_t1", p_vs, 1'b0); idle(1);
    check("lat_vs_t2", p_vs, 1'b1); idle(1);
    check("lat_vs_t3", p_vs, 1'b0); idle(2);
    drive_cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check("lat_hr_t1", p_hr, 1'b0); idle(1);
    check("lat_hr_t2", p_hr, 1'b1); idle(1);
    check("lat_hr_t3", p_hr, 1'b0); idle(2);
    drive_cycle(0, 0, 1, 1, 1, 1, 0, 0);
    check("lat_ck_t1", p_ck, 1'b0); idle(1);
    check("lat_ck_t2", p_ck, 1'b1); idle(1);
    check("lat_ck_t3", p_ck, 1'b0); idle(2);

    run_frame(2'b01, 1, 0, 1, 0, H, 0); erode_checks("erode");
    run_frame(2'b10, 2, 0, 0, 0, H, 0); dilate_checks("dilate");
    run_frame(2'b10, 2, 1, 0, 0, H, 0); dilate_checks("dilate_gap");
    run_frame(2'b01, 1, 1, 0, 0, H, 0); erode_checks("erode_gap");
    run_frame(2'b00, 3, 0, 0, 1, H, 0);
    check("bypass_11", dut_grid[1][1], 1'b0);
    check("bypass_12", dut_grid[1][2], 1'b1);
    check("bypass_44", dut_grid[4][4], 1'b0);
    check("bypass_45", dut_grid[4][5], 1'b1);
    run_frame(2'b01, 1, 0, 0, 0, H, 0); erode_checks("erode_after_toggle");

    // Random frames, including over-long lines and over-tall frames.
    for (int f = 0; f < 8; f++)
      run_frame(2'($urandom), 0, 1'($urandom), 1'($urandom), 0,
                (f % 2) ? H + 3 : H, 1'b1);

    // Reset in the middle of a dilate frame.
    for (int r = 0; r < MAXR; r++)
      for (int c = 0; c < MAXC; c++) img[r][c] = rb();
    mode = 2'b10;
    idle(2);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int r = 0; r < 3; r++) feed_line(r, W, 0);
    for (int c = 0; c < 4; c++) pixel(3, c);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_vsync", p_vs, 1'b0);
    check("midreset_href", p_hr, 1'b0);
    check("midreset_clken", p_ck, 1'b0);
    check("midreset_bit", p_bit, 1'b0);
    reset_model();
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst_n = 1'b1;
    // No vsync yet: mode input says dilate but bypass must stay in force.
    for (int c = 0; c < 6; c++) pixel(4, c);
    idle(3);
    run_frame(2'b01, 1, 0, 0, 0, H, 0); erode_checks("erode_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
